// File: rtl/uart_tx_arbiter.sv
// Round-robin front end that shares one uart_tx serializer between NUM_REQ
// byte producers, with a watchdog that aborts frames whose tx_done never rises.
//
// Handshake: a requester raises req_valid[i] with req_data held stable; the word
// is taken by the edge that enters START, and req_ready[i] is high during START
// only. A req_valid still high in the following IDLE cycle is a new word.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 65535,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          timeout_err,
  output logic [1:0]                    dbg_state,
  output logic [ID_W-1:0]               dbg_ptr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_grant_id;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_done_q;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_found;
  logic [ID_W-1:0]       w_win;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_done_rise;
  logic                  w_cnt_hit;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Search upward from the pointer with wrap-around; first valid bit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_win_data  = req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
  // Only a fresh rising edge counts, so a level left high by the last frame is ignored.
  assign w_done_rise = tx_done & ~r_done_q;
  assign w_cnt_hit   = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (w_done_rise || w_cnt_hit) w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pulses decode straight from the state register so an async reset withdraws them at once.
  always_comb begin
    tx_start    = 1'b0;
    req_ready   = '0;
    busy        = 1'b1;
    timeout_err = 1'b0;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_START: begin
        tx_start  = 1'b1;
        req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;
      end
      S_WAIT:  timeout_err = w_cnt_hit & ~w_done_rise;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_tx_data  <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_done_q   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_done_q <= tx_done;
      if (r_state == S_IDLE && w_found) begin
        r_tx_data  <= w_win_data;
        r_grant_id <= w_win;
        r_ptr      <= wrap_add(w_win, 1);
      end
      // Watchdog runs only in WAIT and saturates rather than wrapping.
      if (r_state != S_WAIT) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;
  assign dbg_state = r_state;
  assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester agents, a uart_tx stand-in driving tx_done
// waveforms, and a scoreboard fed by a rule-level model of grant order and frame end.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 100;
  localparam int IW = 2;
  localparam int W  = IW + DW;
  localparam int WL = 128;

  typedef struct { int s; int e; bit to; } fexp_t;
  typedef struct { int f; int keep; bit hold; } wspec_t;

  logic           clk = 1'b0;
  logic           arstn = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]  req_ready;
  logic           tx_start;
  logic [DW-1:0]  tx_data;
  logic           tx_done = 1'b0;
  logic           busy;
  logic [IW-1:0]  grant_id;
  logic           timeout_err;
  logic [1:0]     dbg_state;
  logic [IW-1:0]  dbg_ptr;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .arstn(arstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  fexp_t        fexp_q[$];
  wspec_t       wdir_q[$];
  logic [DW-1:0] bw [NR][8];
  int           bn [NR];
  int           bpos [NR];
  int           model_ptr = 0;
  bit           wv [WL];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic wspec_t rand_spec();
    wspec_t s;
    s.f    = $urandom_range(1, 25);
    s.keep = ($urandom_range(0, 3) == 0) ? $urandom_range(0, s.f - 1) : 0;
    s.hold = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  task automatic push_spec(input int f, input int keep, input bit hold);
    wspec_t s;
    s.f = f; s.keep = keep; s.hold = hold;
    wdir_q.push_back(s);
  endtask

  task automatic clear_batch();
    for (int i = 0; i < NR; i++) begin
      bn[i] = 0;
      bpos[i] = 0;
    end
  endtask

  // Environment: uart_tx stand-in plus requester agents.
  initial begin : env
    int off;
    bit act;
    bit cur;
    logic [NR-1:0] rdy;
    wspec_t sp;
    fexp_t fe;
    act = 1'b0;
    off = 0;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      if (!arstn) begin
        act = 1'b0;
      end else if (tx_start) begin
        if (wdir_q.size() > 0) sp = wdir_q.pop_front();
        else sp = rand_spec();
        cur = tx_done;
        wv[0] = cur;
        for (int k = 1; k < WL; k++)
          wv[k] = (k <= sp.keep) ? cur : ((k == sp.f) || (sp.hold && k >= sp.f));
        // Frame ends at the first rise within TO wait cycles, otherwise it times out.
        fe.s = cyc; fe.e = TO; fe.to = 1'b1;
        for (int k = 1; k <= TO; k++) begin
          if (wv[k] && !wv[k-1]) begin
            fe.e = k; fe.to = 1'b0;
            break;
          end
        end
        fexp_q.push_back(fe);
        act = 1'b1;
        off = 0;
      end
      @(posedge clk); #1;
      if (!arstn) begin
        tx_done = 1'b0;
        act = 1'b0;
      end else begin
        if (act) begin
          if (off < WL - 1) off++;
          tx_done = wv[off];
        end
        for (int i = 0; i < NR; i++) begin
          if (rdy[i]) begin
            if (bpos[i] < bn[i]) begin
              req_data[i*DW +: DW] = bw[i][bpos[i]];
              bpos[i]++;
            end else begin
              req_valid[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    logic [DW-1:0] held;
    int rel;
    if (arstn) begin
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_ready", int'(req_ready), 1 << e[W-1:DW]);
          chk("grant_data", int'(tx_data), int'(e[DW-1:0]));
          chk("grant_id", int'(grant_id), int'(e[W-1:DW]));
        end
        held = tx_data;
      end else begin
        if (req_ready != '0) chk("stray_ready", int'(req_ready), 0);
        if (busy) chk("data_hold", int'(tx_data), int'(held));
      end
      if (fexp_q.size() > 0 && cyc > fexp_q[0].s) begin
        rel = cyc - fexp_q[0].s;
        if (rel < fexp_q[0].e) begin
          if (timeout_err) chk("early_timeout", 1, 0);
          if (!busy) chk("early_idle", 0, 1);
        end else if (rel == fexp_q[0].e) begin
          chk("timeout_at_end", int'(timeout_err), int'(fexp_q[0].to));
        end else if (rel == fexp_q[0].e + 1) begin
          chk("gap_busy", int'(busy), 1);
          chk("gap_timeout", int'(timeout_err), 0);
        end else begin
          chk("idle_after_gap", int'(busy), 0);
          void'(fexp_q.pop_front());
        end
      end else if (timeout_err) begin
        chk("stray_timeout", 1, 0);
      end
    end
  end

  // Driver: predicts grant order by the rotate-from-pointer rule, applies, drains.
  task automatic run_batch(input string name);
    int rem [NR];
    int tot;
    int p;
    bit ok;
    p = model_ptr;
    tot = 0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = bn[i];
      tot += bn[i];
    end
    while (tot > 0) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (p + k) % NR;
        if (rem[i] > 0) begin
          exp_q.push_back({IW'(i), bw[i][bn[i] - rem[i]]});
          rem[i]--;
          tot--;
          p = (i + 1) % NR;
          break;
        end
      end
    end
    model_ptr = p;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      bpos[i] = 0;
      if (bn[i] > 0) begin
        req_data[i*DW +: DW] = bw[i][0];
        bpos[i] = 1;
        req_valid[i] = 1'b1;
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk({name, "_latency"}, int'(tx_start), 1);
    ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fexp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_drain"}, int'(ok), 1);
    chk({name, "_ptr"}, int'(dbg_ptr), model_ptr);
  endtask

  initial begin : global_guard
    #1000000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_ptr", int'(dbg_ptr), 0);
    chk("rst_state", int'(dbg_state), 0);
    #2 arstn = 1'b1;

    clear_batch();
    bn[1] = 1; bw[1][0] = DW'($urandom);
    bn[3] = 1; bw[3][0] = DW'($urandom);
    run_batch("simul");

    clear_batch();
    bn[2] = 1; bw[2][0] = 8'hC9;
    run_batch("single");

    clear_batch();
    for (int i = 0; i < NR; i++) begin
      bn[i] = 2;
      bw[i][0] = 8'h10 + DW'(i);
      bw[i][1] = 8'h10 + DW'(i);
    end
    run_batch("contend");

    clear_batch();
    push_spec(1000, 0, 1'b0);
    bn[0] = 1; bw[0][0] = DW'($urandom);
    run_batch("watchdog");
    clear_batch();
    bn[0] = 1; bw[0][0] = DW'($urandom);
    run_batch("after_wd");

    clear_batch();
    push_spec(5, 0, 1'b1);
    push_spec(10, 6, 1'b0);
    bn[0] = 1; bw[0][0] = DW'($urandom);
    bn[1] = 1; bw[1][0] = DW'($urandom);
    run_batch("level_held");

    clear_batch();
    push_spec(TO, 0, 1'b0);
    bn[3] = 1; bw[3][0] = DW'($urandom);
    run_batch("tie");

    for (int r = 0; r < 6; r++) begin
      int tot;
      clear_batch();
      tot = 0;
      for (int i = 0; i < NR; i++) begin
        bn[i] = $urandom_range(0, 3);
        tot += bn[i];
        for (int j = 0; j < bn[i]; j++) bw[i][j] = DW'($urandom);
      end
      if (tot == 0) begin
        bn[r % NR] = 1;
        bw[r % NR][0] = DW'($urandom);
      end
      run_batch("random");
    end

    // Reset while a frame sits in WAIT.
    clear_batch();
    push_spec(1000, 0, 1'b0);
    exp_q.push_back({IW'(1), 8'h77});
    bn[1] = 1; bpos[1] = 1;
    @(posedge clk); #1;
    req_data[1*DW +: DW] = 8'h77;
    req_valid[1] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_mid_start_seen", int'(ok), 1);
    repeat (10) @(negedge clk);
    chk("rst_mid_busy_before", int'(busy), 1);
    #2 arstn = 1'b0;
    #1;
    chk("rst_mid_tx_start", int'(tx_start), 0);
    chk("rst_mid_req_ready", int'(req_ready), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_grant_id", int'(grant_id), 0);
    chk("rst_mid_tx_data", int'(tx_data), 0);
    chk("rst_mid_timeout_err", int'(timeout_err), 0);
    chk("rst_mid_ptr", int'(dbg_ptr), 0);
    exp_q.delete();
    fexp_q.delete();
    wdir_q.delete();
    req_valid = '0;
    model_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    #2 arstn = 1'b1;
    clear_batch();
    bn[0] = 1; bw[0][0] = DW'($urandom);
    bn[3] = 1; bw[3][0] = DW'($urandom);
    run_batch("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` serializer between `NUM_REQ` byte producers. It accepts words through per-requester valid/ready handshakes and launches each frame on the serializer with a one-cycle `tx_start`. It holds the serializer's data input stable until the frame completes, then releases it. A watchdog aborts a frame whose `tx_done` never arrives. The block sits directly in front of `uart_tx`, and its `tx_*` outputs connect one-to-one to that module's ports.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: word width; must match `uart_tx`.
- `TIMEOUT`, 65535: WAIT cycles allowed before abort; must be ≥2 and exceed one frame time.
- `clk` in 1: system clock; all logic on the rising edge.
- `arstn` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: bit i means requester i has a word pending.
- `req_data` in NUM_REQ*DATA_WIDTH: requester i's word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` out NUM_REQ: one-hot, one-cycle accept pulse to the granted requester.
- `tx_start` out 1: to `uart_tx.tx_start`; one-cycle pulse per frame.
- `tx_data` out DATA_WIDTH: to `uart_tx.tx_data`; registered.
- `tx_done` in 1: from `uart_tx.tx_done`; frame-complete indication.
- `busy` out 1: high whenever state ≠ IDLE.
- `grant_id` out clog2(NUM_REQ): index of the last accepted requester; registered.
- `timeout_err` out 1: one-cycle pulse when a frame is aborted.

## Operation
- FSM states: IDLE, START, WAIT, GAP.
- **IDLE**
  - If any `req_valid` bit is high, at the next edge the arbiter picks the winner w.
  - w is the first set bit searching upward, with wrap-around, from index `ptr`.
  - On that edge: latch `req_data[w]` into `tx_data`, set `grant_id`=w, set `ptr`=(w+1) mod NUM_REQ, set `req_ready[w]`=1, set `tx_start`=1, go to START.
  - If no bit is high, stay in IDLE with all pulses low.
- **START** (exactly one cycle)
  - `tx_start` and `req_ready[w]` are high.
  - Next state is WAIT, with `tx_start`=0, `req_ready`=0 and the watchdog counter cleared.
- **WAIT**
  - `done_q` registers `tx_done` every cycle in every state.
  - Completion is a rising edge: `tx_done`=1 and `done_q`=0. A `tx_done` held high from the previous frame does not count.
  - On completion, go to GAP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1, pulse `timeout_err` for one cycle and go to GAP.
  - If completion and timeout occur in the same cycle, completion wins and `timeout_err` stays 0.
- **GAP**: one cycle, then IDLE. This guarantees `uart_tx` returns idle before the next start.
- `tx_data` stays constant from START through GAP. It changes only on a grant.
- Handshake rules for requesters:
  - Hold `req_valid` and `req_data` stable until `req_ready` is seen.
  - The accepted word is gone after the edge ending START.
  - `req_valid` still high in the next IDLE cycle is treated as a new word.
  - Deasserting `req_valid` before grant is legal; nothing is latched.
  - Request bits that go high while the FSM is outside IDLE are ignored until IDLE.
- Counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset values: state=IDLE, `ptr`=0, `tx_start`=0, `tx_data`=0, `req_ready`=0, `busy`=0, `grant_id`=0, `timeout_err`=0, `done_q`=0, counter=0.
- Reset mid-operation (any state): all outputs return to reset values immediately. A pending `tx_start` is withdrawn, and no `req_ready` or `timeout_err` is emitted.
- Latency:
  - `req_valid` high in IDLE at edge k → `tx_start` and `req_ready` high in the cycle after edge k.
  - Completion edge sampled at edge m → GAP in cycle m+1, IDLE in m+2, earliest next `tx_start` in m+3.
- Minimum spacing between `tx_start` pulses is frame time + 3 cycles.
- Fairness: a requester that is continuously valid is granted within NUM_REQ grants.

## Test plan
- Single request:
  - Stimulus: `req_valid`=4'b0100, data2=8'hC9.
  - Required: `tx_start` pulses once, `tx_data`=8'hC9, `req_ready`=4'b0100 for one cycle, `grant_id`=2, then `busy` drops two cycles after the `tx_done` rise.
- Simultaneous requests:
  - Stimulus: `req_valid`=4'b1010 held, each requester dropping valid after its ready.
  - Required: grants in order 1, then 3; `ptr` ends at 0.
- Continuous contention:
  - Stimulus: all four valid permanently, data i=8'h10+i.
  - Required: `tx_data` sequence 10,11,12,13,10; exactly one `req_ready` bit per frame.
- Watchdog:
  - Stimulus: TIMEOUT=100, `tx_done` tied 0.
  - Required: `timeout_err` pulses once, exactly 100 cycles into WAIT; `busy` low two cycles after that; next request served normally.
- Level-held done:
  - Stimulus: `tx_done` held 1 across the next START.
  - Required: no completion until `tx_done` falls and rises again.
  - Stimulus: `tx_done` rising in the same cycle the counter reaches TIMEOUT-1.
  - Required: completion taken, no `timeout_err`.
- Reset mid-WAIT:
  - Stimulus: `arstn` pulled low while in WAIT.
  - Required: all outputs reset immediately, `ptr`=0. After release with `req_valid`=4'b1001, requester 0 is granted first.
